// File: rtl/cpu_pkg.sv
// Shared constants for the single-cycle R-type CPU:
// R-type opcode, funct codes and ALU operation encodings.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;

  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLLV = 6'h04;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_XOR  = 3'b010,
    ALU_NOR  = 3'b011,
    ALU_ADD  = 3'b100,
    ALU_SUB  = 3'b101,
    ALU_SLT  = 3'b110,
    ALU_SLLV = 3'b111
  } alu_op_t;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU.
// Ports: a, b (operands), op (alu_op_t) -> f, zf, of.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     op,
  output logic [31:0] f,
  output logic        zf,
  output logic        of
);

  always_comb begin
    f  = '0;
    of = 1'b0;
    unique case (op)
      ALU_AND:  f = a & b;
      ALU_OR:   f = a | b;
      ALU_XOR:  f = a ^ b;
      ALU_NOR:  f = ~(a | b);
      ALU_ADD: begin
        f  = a + b;
        // same-sign operands, result sign differs
        of = (a[31] == b[31]) && (f[31] != a[31]);
      end
      ALU_SUB: begin
        f  = a - b;
        // opposite-sign operands, result sign differs
        of = (a[31] != b[31]) && (f[31] != a[31]);
      end
      ALU_SLT:  f = {31'd0, $signed(a) < $signed(b)};
      ALU_SLLV: f = b << a[4:0];
      default:  f = '0;
    endcase
  end

  assign zf = (f == '0);

endmodule

// File: rtl/cpu.sv
// Single-cycle R-type CPU: decode, 32x32 register file, ALU.
// Ports: clk, rst (async, active high), Inst_code in;
//   CPU_F/CPU_ZF/CPU_OF registered result/flags;
//   A, B, ALU_OP, Addr, Data, F, ZF, OF combinational.
// Option: CPU_R0_HARDWIRE_EN makes $0 read 0, ignore writes.
module cpu
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Inst_code,
  output logic [31:0] CPU_F,
  output logic        CPU_ZF,
  output logic        CPU_OF,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [2:0]  ALU_OP,
  output logic [4:0]  Addr,
  output logic [31:0] Data,
  output logic [31:0] F,
  output logic        ZF,
  output logic        OF
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;

  assign op    = Inst_code[31:26];
  assign rs    = Inst_code[25:21];
  assign rt    = Inst_code[20:16];
  assign rd    = Inst_code[15:11];
  assign funct = Inst_code[5:0];

  logic unused_shamt;
  assign unused_shamt = ^Inst_code[10:6];

  logic [7:0] hit;
  logic       valid;
  alu_op_t    alu_op;

  always_comb begin
    hit = '0;
    if (op == OP_RTYPE) begin
      hit[0] = (funct == FN_AND);
      hit[1] = (funct == FN_OR);
      hit[2] = (funct == FN_XOR);
      hit[3] = (funct == FN_NOR);
      hit[4] = (funct == FN_ADD);
      hit[5] = (funct == FN_SUB);
      hit[6] = (funct == FN_SLT);
      hit[7] = (funct == FN_SLLV);
    end
  end

  assign valid = |hit;

  // funct codes are distinct, so at most one hit bit is set
  always_comb begin
    alu_op = ALU_AND;
    unique case (1'b1)
      hit[0]:  alu_op = ALU_AND;
      hit[1]:  alu_op = ALU_OR;
      hit[2]:  alu_op = ALU_XOR;
      hit[3]:  alu_op = ALU_NOR;
      hit[4]:  alu_op = ALU_ADD;
      hit[5]:  alu_op = ALU_SUB;
      hit[6]:  alu_op = ALU_SLT;
      hit[7]:  alu_op = ALU_SLLV;
      default: alu_op = ALU_AND;
    endcase
  end

  assign ALU_OP = alu_op;

  logic [31:0] rf [32];
  logic        we;

`ifdef CPU_R0_HARDWIRE_EN
  assign A  = (rs == 5'd0) ? '0 : rf[rs];
  assign B  = (rt == 5'd0) ? '0 : rf[rt];
  assign we = valid && (rd != 5'd0);
`else
  assign A  = rf[rs];
  assign B  = rf[rt];
  assign we = valid;
`endif

  cpu_alu u_alu (
    .a  (A),
    .b  (B),
    .op (alu_op),
    .f  (F),
    .zf (ZF),
    .of (OF)
  );

  assign Addr = rd;
  assign Data = F;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        rf[i] <= '0;
      end
    end else if (we) begin
      rf[rd] <= F;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      CPU_F  <= '0;
      CPU_ZF <= 1'b0;
      CPU_OF <= 1'b0;
    end else if (valid) begin
      CPU_F  <= F;
      CPU_ZF <= ZF;
      CPU_OF <= OF;
    end
  end

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: directed steps plus
// randomized R-type traffic against a behavioural model.
module tb_cpu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Inst_code;
  logic [31:0] CPU_F;
  logic        CPU_ZF;
  logic        CPU_OF;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  ALU_OP;
  logic [4:0]  Addr;
  logic [31:0] Data;
  logic [31:0] F;
  logic        ZF;
  logic        OF;

  cpu dut (
    .clk       (clk),
    .rst       (rst),
    .Inst_code (Inst_code),
    .CPU_F     (CPU_F),
    .CPU_ZF    (CPU_ZF),
    .CPU_OF    (CPU_OF),
    .A         (A),
    .B         (B),
    .ALU_OP    (ALU_OP),
    .Addr      (Addr),
    .Data      (Data),
    .F         (F),
    .ZF        (ZF),
    .OF        (OF)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_rf [32];
  logic [31:0] m_cf;
  logic        m_czf;
  logic        m_cof;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] r);
`ifdef CPU_R0_HARDWIRE_EN
    if (r == 5'd0) return 32'd0;
`endif
    return m_rf[r];
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_cf  = '0;
    m_czf = 1'b0;
    m_cof = 1'b0;
  endfunction

  // Evaluate an instruction from the ISA rules using wide
  // signed arithmetic for overflow detection.
  function automatic void model(
    input  logic [31:0] inst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        v,
    output logic [2:0]  op,
    output logic [31:0] f,
    output logic        of
  );
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint r;
    v  = 1'b0;
    op = 3'd0;
    f  = a & b;
    of = 1'b0;
    r  = 0;
    if (inst[31:26] == 6'd0) begin
      case (inst[5:0])
        6'h24: begin v = 1; op = 3'd0; f = a & b; end
        6'h25: begin v = 1; op = 3'd1; f = a | b; end
        6'h26: begin v = 1; op = 3'd2; f = a ^ b; end
        6'h27: begin v = 1; op = 3'd3; f = ~(a | b); end
        6'h20: begin
          v = 1; op = 3'd4; r = sa + sb; f = r[31:0];
          of = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        end
        6'h22: begin
          v = 1; op = 3'd5; r = sa - sb; f = r[31:0];
          of = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        end
        6'h2A: begin
          v = 1; op = 3'd6; f = (sa < sb) ? 32'd1 : 32'd0;
        end
        6'h04: begin
          v = 1; op = 3'd7; f = b << (a % 32);
        end
        default: ;
      endcase
    end
  endfunction

  task automatic step(input logic [31:0] inst);
    logic        v;
    logic [2:0]  op;
    logic [31:0] a, b, f;
    logic        of;
    logic [4:0]  rd;
    @(negedge clk);
    Inst_code = inst;
    #1;
    a  = m_read(inst[25:21]);
    b  = m_read(inst[20:16]);
    rd = inst[15:11];
    model(inst, a, b, v, op, f, of);
    chk("A", A, a);
    chk("B", B, b);
    chk("ALU_OP", {29'd0, ALU_OP}, {29'd0, op});
    chk("F", F, f);
    chk("ZF", {31'd0, ZF}, {31'd0, f == 0});
    chk("OF", {31'd0, OF}, {31'd0, of});
    chk("Addr", {27'd0, Addr}, {27'd0, rd});
    chk("Data", Data, f);
    @(posedge clk);
    #1;
    if (v) begin
      m_rf[rd] = f;
      m_cf  = f;
      m_czf = (f == 0);
      m_cof = of;
    end
    chk("CPU_F", CPU_F, m_cf);
    chk("CPU_ZF", {31'd0, CPU_ZF}, {31'd0, m_czf});
    chk("CPU_OF", {31'd0, CPU_OF}, {31'd0, m_cof});
  endtask

  // Read a register through port A using a non-R-type word.
  task automatic probe(input logic [4:0] r,
                       input logic [31:0] exp);
    @(negedge clk);
    Inst_code = {6'h3F, r, 5'd0, 16'd0};
    #1;
    chk($sformatf("reg%0d", r), A, exp);
  endtask

  logic [5:0] fn_tab [9];

  initial begin
    logic [31:0] inst;
    fn_tab[0] = 6'h24; fn_tab[1] = 6'h25; fn_tab[2] = 6'h26;
    fn_tab[3] = 6'h27; fn_tab[4] = 6'h20; fn_tab[5] = 6'h22;
    fn_tab[6] = 6'h2A; fn_tab[7] = 6'h04; fn_tab[8] = 6'h3F;

    m_reset();
    rst = 1'b1;
    Inst_code = 32'd0;
    #3;
    chk("rst_CPU_F", CPU_F, 32'd0);
    chk("rst_CPU_ZF", {31'd0, CPU_ZF}, 32'd0);
    chk("rst_CPU_OF", {31'd0, CPU_OF}, 32'd0);
    chk("rst_A", A, 32'd0);
    chk("rst_B", B, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    step(32'h0000_0000);
    probe(5'd0, 32'd0);

    step(32'h0000_0827);
    probe(5'd1, 32'hFFFF_FFFF);
    chk("nor_CPU_F", CPU_F, 32'hFFFF_FFFF);
    step(32'h0001_1822);
    probe(5'd3, 32'd1);
    step(32'h0020_202A);
    probe(5'd4, 32'd1);
    step(32'h0021_2822);
    chk("sub_CPU_ZF", {31'd0, CPU_ZF}, 32'd1);
    step(32'h0023_3004);
    probe(5'd6, 32'h8000_0000);
    step(32'h0006_3822);
    chk("ovf_CPU_OF", {31'd0, CPU_OF}, 32'd1);
    probe(5'd7, 32'h8000_0000);
    step(32'h0023_403F);
    probe(5'd8, 32'd0);
    chk("nop_CPU_F", CPU_F, 32'h8000_0000);
    step(32'h0000_0027);
`ifdef CPU_R0_HARDWIRE_EN
    probe(5'd0, 32'd0);
`else
    probe(5'd0, 32'hFFFF_FFFF);
`endif

    for (int i = 0; i < 300; i++) begin
      inst = $urandom;
      inst[5:0] = fn_tab[$urandom_range(0, 8)];
      if ($urandom_range(0, 9) != 0) inst[31:26] = 6'd0;
      step(inst);
    end

    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    m_reset();
    chk("arst_CPU_F", CPU_F, 32'd0);
    chk("arst_CPU_ZF", {31'd0, CPU_ZF}, 32'd0);
    chk("arst_CPU_OF", {31'd0, CPU_OF}, 32'd0);
    chk("arst_A", A, 32'd0);
    chk("arst_B", B, 32'd0);
    for (int r = 0; r < 32; r++) probe(5'(r), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 100; i++) begin
      inst = $urandom;
      inst[5:0] = fn_tab[$urandom_range(0, 8)];
      if ($urandom_range(0, 9) != 0) inst[31:26] = 6'd0;
      step(inst);
    end
    for (int r = 0; r < 32; r++) probe(5'(r), m_read(5'(r)));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu.md
CPU -- requirements
Module: cpu

Interface
REQ-001 SHALL use one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-002 SHALL provide: rst  input  1  asynchronous active-high reset.
REQ-003 SHALL provide: Inst_code  input  32  instruction word, R-type format: op[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0].
REQ-004 SHALL provide: CPU_F  output  32  registered result of the last executed instruction.
REQ-005 SHALL provide: CPU_ZF / CPU_OF  output  1 each  registered zero and overflow flags of the last executed instruction.
REQ-006 SHALL provide: A / B  output  32 each  register-file read data for rs / rt; combinational.
REQ-007 SHALL provide: ALU_OP  output  3  decoded ALU operation; combinational.
REQ-008 SHALL provide: Addr  output  5  write address, equal to rd.
REQ-009 SHALL provide: Data  output  32  write-back data, equal to F.
REQ-010 SHALL provide: F / ZF / OF  output  32/1/1  combinational ALU result, zero flag and overflow flag.

Function
REQ-011 SHALL decode only op=000000; funct map: 0x24 AND=000, 0x25 OR=001, 0x26 XOR=010, 0x27 NOR=011, 0x20 ADD=100, 0x22 SUB=101, 0x2A SLT=110, 0x04 SLLV=111.
REQ-012 SHALL treat any other op/funct as NOP: ALU_OP=000, no register write, CPU_* hold.
REQ-013 SHALL compute F from A (rs) and B (rt); SLLV F = B << A[4:0]; SLT F = 1 if A < B signed, else 0; ADD/SUB wrap modulo 2^32.
REQ-014 SHALL set OF = 1 only on signed overflow of ADD or SUB, and OF = 0 for all other ops; ZF = (F == 0).
REQ-015 SHALL keep a 32x32 register file with two asynchronous read ports (rs, rt) and one synchronous write port (rd).
REQ-016 SHALL write F to register rd on every rising clk edge with a valid instruction and rst low.
REQ-017 SHALL load CPU_F/CPU_ZF/CPU_OF with F/ZF/OF on the same edge as the register write, giving one-cycle latency.
REQ-018 SHALL make reads in the cycle after a write return the new value; a read in the same cycle as a write returns the old value (no bypass).

Reset
REQ-019 SHALL, while rst=1, asynchronously clear all 32 registers and set CPU_F=0, CPU_ZF=0 and CPU_OF=0, and SHALL block writes.
REQ-020 SHALL keep the combinational outputs driven from the cleared state during reset, so A=B=0.

Configuration
REQ-021 With CPU_R0_HARDWIRE_EN defined, register 0 SHALL always read 0 and writes to it SHALL be discarded; CPU_* SHALL still update.
REQ-022 Without CPU_R0_HARDWIRE_EN, register 0 SHALL be an ordinary writable register.

Structure
REQ-023 SHALL place the ALU_OP encodings, funct constants and the R-type opcode in a shared package, cpu_pkg.
REQ-024 SHALL implement the ALU as one sub-module, cpu_alu (A, B, ALU_OP -> F, ZF, OF); the register file and decode SHALL stay in cpu.

Verification
REQ-025 Reset: rst=1, Inst_code=0 -> CPU_F=0, CPU_ZF=0, CPU_OF=0, A=B=0; Inst_code=0 after reset -> no write.
REQ-026 NOR: 0x00000827 -> ALU_OP=011, F=0xFFFFFFFF, ZF=0, OF=0; after the edge, $1=0xFFFFFFFF and CPU_F=0xFFFFFFFF.
REQ-027 SUB/SLT: 0x00011822 -> $3=1; 0x0020202A -> $4=1 (-1<0); 0x00212822 -> F=0, ZF=1, and CPU_ZF=1 after the edge.
REQ-028 SLLV/overflow: 0x00233004 -> $6=0x80000000; 0x00063822 -> F=0x80000000, OF=1, and CPU_OF=1 after the edge.
REQ-029 NOP/R0: funct 0x3F -> no register change and CPU_* hold; with CPU_R0_HARDWIRE_EN, 0x00000027 (NOR into $0) -> $0 still reads 0.
REQ-030 Async reset mid-run: assert rst between clock edges -> all outputs and registers cleared immediately, without waiting for a clock edge.
